// File: rtl/aes_pkg.sv
// aes_pkg: shared AES S-box, GF helpers, key-length derivations and FSM state type
package aes_pkg;
  typedef enum logic [1:0] {AES128, AES192, AES256} key_len_e;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_e;
  localparam int WORD_BITS = 32;
  localparam int RK_WORDS = 4;
  localparam int RK_BITS = WORD_BITS * RK_WORDS;
  // entry 0 sits in the MSBs
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction
  function automatic logic [7:0] aes128_sbox(input logic [7:0] b);
    return sbox(b);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction
  function automatic int nr_of(input int kb);
    return nk_of(kb) + 6;
  endfunction
  function automatic int nw_of(input int kb);
    return 4 * (nr_of(kb) + 1);
  endfunction
  function automatic key_len_e key_len(input int kb);
    return kb == 256 ? AES256 : kb == 192 ? AES192 : AES128;
  endfunction
endpackage

// File: rtl/aes_key_schedule_store_if.sv
// aes_key_schedule_store_if: key load, status and round-key read bus
interface aes_key_schedule_store_if #(parameter int KEY_BITS = 128);
  logic [KEY_BITS-1:0] key_in;
  logic key_load;
  logic busy;
  logic key_ready;
  logic rk_rd_en;
  logic [3:0] rk_idx;
  logic [127:0] rk_out;
  logic rk_out_valid;
  logic rk_err;
  modport master(output key_in, key_load, rk_rd_en, rk_idx,
                 input busy, key_ready, rk_out, rk_out_valid, rk_err);
  modport slave(input key_in, key_load, rk_rd_en, rk_idx,
                output busy, key_ready, rk_out, rk_out_valid, rk_err);
endinterface

// File: rtl/aes_key_word_gen.sv
// aes_key_word_gen: next expanded key word from w[i-1], w[i-NK], phase and rcon
module aes_key_word_gen
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [31:0] prev,
  input  logic [31:0] old,
  input  logic [2:0]  phase,
  input  logic [7:0]  rcon,
  output logic [31:0] word
);
  logic [31:0] pre;
  logic [31:0] sub;
  // one SubWord shared by the rotated and the AES-256 mid-key case
  always_comb begin
    pre = phase == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    sub = sub_word(pre);
    word = old ^ (phase == 3'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && phase == 3'd4) ? sub : prev);
  end
endmodule

// File: rtl/aes_key_schedule_store.sv
// aes_key_schedule_store: expands an AES key once and serves any round key with one-cycle latency
module aes_key_schedule_store
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic clk_sys,
  input logic rst_n,
  aes_key_schedule_store_if.slave bus
);
  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_key_schedule_store: KEY_BITS must be 128, 192 or 256");
  end
  ks_state_e state, nxt;
  logic [31:0] store [NW];
  logic [31:0] win [NK];
  logic [5:0] i;
  logic [2:0] phase;
  logic [7:0] rcon;
  logic [31:0] w_new;
  logic rd_ok;
  aes_key_word_gen #(.NK(NK)) u_gen (
    .prev(win[NK-1]),
    .old(win[0]),
    .phase(phase),
    .rcon(rcon),
    .word(w_new)
  );
  always_comb begin
    nxt = bus.key_load ? EXPAND : (state == EXPAND && i == 6'(NW - 1)) ? READY : state;
    rd_ok = bus.rk_rd_en && !bus.key_load && state == READY && bus.rk_idx <= 4'(NR);
  end
  assign bus.busy = state == EXPAND;
  assign bus.key_ready = state == READY;
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.rk_out_valid <= 1'b0;
      bus.rk_err <= 1'b0;
      bus.rk_out <= '0;
    end else begin
      state <= nxt;
      bus.rk_out_valid <= rd_ok;
      bus.rk_err <= bus.rk_rd_en && !rd_ok;
      if (rd_ok)
        bus.rk_out <= {store[{bus.rk_idx, 2'd0}], store[{bus.rk_idx, 2'd1}],
                       store[{bus.rk_idx, 2'd2}], store[{bus.rk_idx, 2'd3}]};
    end
  end
  // window[0] is w[i-NK], window[NK-1] is w[i-1]
  always_ff @(posedge clk_sys) begin
    if (bus.key_load) begin
      for (int k = 0; k < NK; k++) begin
        win[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
        store[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
      end
      i <= 6'(NK);
      phase <= 3'd0;
      rcon <= 8'h01;
    end else if (state == EXPAND) begin
      store[i] <= w_new;
      for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
      win[NK-1] <= w_new;
      i <= i + 6'd1;
      phase <= phase == 3'(NK - 1) ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) rcon <= xtime(rcon);
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_store.sv
// tb_aes_key_schedule_store: checks AES-128/192/256 instances against a FIPS-197 key-expansion model
module tb_aes_key_schedule_store;
  typedef struct {
    int d;
    int cyc;
    int kind;
    logic [127:0] val;
    string name;
  } lit_t;
  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a [3];
  logic load_a [3];
  logic rd_a [3];
  logic [3:0] idx_a [3];
  logic [255:0] key_a [3];
  logic busy_a [3];
  logic rdy_a [3];
  logic val_a [3];
  logic err_a [3];
  logic [127:0] out_a [3];
  logic [7:0] sb [256];
  logic [31:0] sched [3][60];
  logic e_busy [3];
  logic e_rdy [3];
  logic e_val [3];
  logic e_err [3];
  logic [127:0] e_out [3];
  bit armed [3];
  int cnt [3];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_lit = 0;
  bit done = 1'b0;
  lit_t lits [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
    aes_key_schedule_store_if #(.KEY_BITS(KB)) bus ();
    assign bus.key_in = key_a[g][KB-1:0];
    assign bus.key_load = load_a[g];
    assign bus.rk_rd_en = rd_a[g];
    assign bus.rk_idx = idx_a[g];
    assign busy_a[g] = bus.busy;
    assign rdy_a[g] = bus.key_ready;
    assign val_a[g] = bus.rk_out_valid;
    assign err_a[g] = bus.rk_err;
    assign out_a[g] = bus.rk_out;
    aes_key_schedule_store #(.KEY_BITS(KB)) dut (.clk_sys(clk), .rst_n(rst_a[g]), .bus(bus));
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x};
    return t[15-n -: 8];
  endfunction
  function automatic logic [31:0] sub4(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion written out with plain modulo arithmetic
  task automatic expand(input int d);
    int nk, nw;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * d;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) sched[d][i] = key_a[d][32*nk-1-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = sched[d][i-1];
      if (i % nk == 0) begin
        t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub4(t);
      end
      sched[d][i] = sched[d][i-nk] ^ t;
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      int nk, nr;
      bit ok;
      nk = 4 + 2 * d;
      nr = nk + 6;
      if (!rst_a[d]) begin
        armed[d] <= 1'b1;
        e_busy[d] <= 1'b0;
        e_rdy[d] <= 1'b0;
        e_val[d] <= 1'b0;
        e_err[d] <= 1'b0;
        e_out[d] <= '0;
      end else begin
        ok = rd_a[d] && !load_a[d] && e_rdy[d] && int'(idx_a[d]) <= nr;
        e_val[d] <= ok;
        e_err[d] <= rd_a[d] && !ok;
        if (ok)
          e_out[d] <= {sched[d][4*idx_a[d]], sched[d][4*idx_a[d]+1],
                       sched[d][4*idx_a[d]+2], sched[d][4*idx_a[d]+3]};
        if (load_a[d]) begin
          expand(d);
          cnt[d] <= 0;
          e_busy[d] <= 1'b1;
          e_rdy[d] <= 1'b0;
        end else if (e_busy[d]) begin
          cnt[d] <= cnt[d] + 1;
          if (cnt[d] + 1 == 4 * (nr + 1) - nk) begin
            e_busy[d] <= 1'b0;
            e_rdy[d] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got %h expected %h", nm, d, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (armed[d]) begin
        chk(busy_a[d] === e_busy[d], "busy", d, 128'(busy_a[d]), 128'(e_busy[d]));
        chk(rdy_a[d] === e_rdy[d], "key_ready", d, 128'(rdy_a[d]), 128'(e_rdy[d]));
        chk(val_a[d] === e_val[d], "rk_out_valid", d, 128'(val_a[d]), 128'(e_val[d]));
        chk(err_a[d] === e_err[d], "rk_err", d, 128'(err_a[d]), 128'(e_err[d]));
        chk(out_a[d] === e_out[d], "rk_out", d, out_a[d], e_out[d]);
      end
    end
    foreach (lits[k]) begin
      if (lits[k].cyc == cyc) begin
        lit_t l;
        logic [127:0] act;
        l = lits[k];
        act = l.kind == 0 ? out_a[l.d] : 128'(l.kind == 1 ? rdy_a[l.d] : l.kind == 2 ? err_a[l.d] :
                                              l.kind == 3 ? busy_a[l.d] : val_a[l.d]);
        chk(act === l.val, l.name, l.d, act, l.val);
        n_lit++;
      end
    end
    if (done) begin
      chk(n_lit == lits.size(), "literals_reached", 0, 128'(n_lit), 128'(lits.size()));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // kind: 0 rk_out, 1 key_ready, 2 rk_err, 3 busy, 4 rk_out_valid
  task automatic expect_at(input int d, input int dc, input int kind, input logic [127:0] val,
                           input string name);
    lit_t l;
    l.d = d;
    l.cyc = cyc + dc;
    l.kind = kind;
    l.val = val;
    l.name = name;
    lits.push_back(l);
  endtask
  task automatic load(input int d, input logic [255:0] key, input bit timed);
    int nk;
    nk = 4 + 2 * d;
    key_a[d] = key;
    load_a[d] = 1'b1;
    if (timed) begin
      expect_at(d, 1, 3, 128'd1, "busy_after_load");
      expect_at(d, 4 * (nk + 7) - nk, 1, 128'd0, "ready_not_early");
      expect_at(d, 4 * (nk + 7) - nk + 1, 1, 128'd1, "ready_latency");
    end
    tick(1);
    load_a[d] = 1'b0;
  endtask
  task automatic rd(input int d, input int idx);
    rd_a[d] = 1'b1;
    idx_a[d] = 4'(idx);
    tick(1);
    rd_a[d] = 1'b0;
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0;
      load_a[d] = 1'b0;
      rd_a[d] = 1'b0;
      idx_a[d] = 4'd0;
      key_a[d] = '0;
    end
    tick(3);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
    expect_at(0, 1, 0, 128'd0, "reset_rk_out");
    expect_at(0, 1, 1, 128'd0, "reset_key_ready");
    expect_at(0, 1, 3, 128'd0, "reset_busy");
    tick(2);
    load(0, K128, 1'b1);
    tick(40);
    expect_at(0, 1, 0, 128'ha0fafe1788542cb123a339392a6c7605, "aes128_rk1");
    expect_at(0, 1, 4, 128'd1, "aes128_rk1_valid");
    rd(0, 1);
    expect_at(0, 1, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10");
    rd(0, 10);
    expect_at(0, 1, 4, 128'd0, "valid_only_one_cycle");
    tick(2);
    for (int r = 10; r >= 0; r--) begin
      expect_at(0, 1, 4, 128'd1, "sweep_valid");
      if (r == 10) expect_at(0, 1, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "sweep_rk10");
      if (r == 1) expect_at(0, 1, 0, 128'ha0fafe1788542cb123a339392a6c7605, "sweep_rk1");
      if (r == 0) expect_at(0, 1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "sweep_rk0");
      rd(0, r);
    end
    expect_at(0, 1, 4, 128'd0, "sweep_end_valid");
    tick(2);
    load(1, K192, 1'b1);
    tick(46);
    expect_at(1, 1, 0, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12");
    rd(1, 12);
    expect_at(1, 1, 2, 128'd1, "aes192_idx13_err");
    expect_at(1, 1, 4, 128'd0, "aes192_idx13_no_valid");
    expect_at(1, 1, 0, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk_out_held");
    rd(1, 13);
    tick(2);
    load(2, K256, 1'b1);
    tick(52);
    expect_at(2, 1, 0, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");
    rd(2, 14);
    expect_at(2, 1, 0, 128'h603deb1015ca71be2b73aef0857d7781, "aes256_rk0");
    rd(2, 0);
    tick(2);
    load(0, 256'h000102030405060708090a0b0c0d0e0f, 1'b0);
    tick(19);
    load(0, K128, 1'b1);
    tick(5);
    expect_at(0, 1, 2, 128'd1, "read_busy_err");
    expect_at(0, 1, 4, 128'd0, "read_busy_no_valid");
    rd(0, 3);
    tick(34);
    expect_at(0, 1, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_rk10");
    rd(0, 10);
    tick(1);
    load_a[0] = 1'b1;
    rd_a[0] = 1'b1;
    idx_a[0] = 4'd2;
    expect_at(0, 1, 2, 128'd1, "load_and_read_err");
    expect_at(0, 1, 1, 128'd0, "load_and_read_ready_falls");
    expect_at(0, 1, 4, 128'd0, "load_and_read_no_valid");
    tick(1);
    load_a[0] = 1'b0;
    rd_a[0] = 1'b0;
    tick(29);
    rst_a[0] = 1'b0;
    expect_at(0, 1, 3, 128'd0, "abort_busy");
    expect_at(0, 1, 1, 128'd0, "abort_ready");
    tick(1);
    rst_a[0] = 1'b1;
    tick(2);
    expect_at(0, 1, 2, 128'd1, "after_abort_err");
    expect_at(0, 20, 1, 128'd0, "after_abort_ready_stays_low");
    rd(0, 1);
    tick(25);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
